alu_issue_stage: RTL

// - Decode/issue stage feeding the ALU: accepts one instruction plus its operands per cycle,

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_op_decode.sv | 106 ++++++++++
 rtl/alu_issue_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes, RV32I opcodes and the issue bundle handed to the ALU.
package alu_pkg;

  localparam int unsigned ALU_XLEN = 32;

  // ALU function codes
  localparam logic [3:0] ALUFN_ADD   = 4'b0000;
  localparam logic [3:0] ALUFN_SUB   = 4'b0001;
  localparam logic [3:0] ALUFN_PASSB = 4'b0011;
  localparam logic [3:0] ALUFN_OR    = 4'b0100;
  localparam logic [3:0] ALUFN_AND   = 4'b0101;
  localparam logic [3:0] ALUFN_XOR   = 4'b0111;
  localparam logic [3:0] ALUFN_SRL   = 4'b1000;
  localparam logic [3:0] ALUFN_SLL   = 4'b1001;
  localparam logic [3:0] ALUFN_SRA   = 4'b1010;
  localparam logic [3:0] ALUFN_SLT   = 4'b1101;
  localparam logic [3:0] ALUFN_SLTU  = 4'b1111;

  // RV32I major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]          alufn;
    logic [ALU_XLEN-1:0] a;
    logic [ALU_XLEN-1:0] b;
    logic [4:0]          shamt;
    logic [4:0]          rd;
    logic                illegal;
  } issue_t;

  // funct3 -> ALU function for the OP/OP-IMM families (base, f7[5]=0 variant)
  function automatic logic [3:0] f3_to_alufn(input logic [2:0] f3);
    logic [3:0] fn;
    case (f3)
      3'b000:  fn = ALUFN_ADD;
      3'b001:  fn = ALUFN_SLL;
      3'b010:  fn = ALUFN_SLT;
      3'b011:  fn = ALUFN_SLTU;
      3'b100:  fn = ALUFN_XOR;
      3'b101:  fn = ALUFN_SRL;
      3'b110:  fn = ALUFN_OR;
      default: fn = ALUFN_AND;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode: instruction + pc + register values -> ALU issue bundle.
// rd is always the raw instr[11:7] field.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output issue_t          bundle
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic            ill;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};

  // Opcode/funct decode; illegal encodings collapse to ADD rs1,rs2 at the end
  always_comb begin
    bundle       = '0;
    bundle.alufn = ALUFN_ADD;
    bundle.a     = rs1;
    bundle.b     = rs2;
    bundle.rd    = instr[11:7];
    ill          = 1'b0;
    case (opcode)
      OPC_OP: begin
        bundle.shamt = rs2[4:0];
        if (f7 == F7_BASE)
          bundle.alufn = f3_to_alufn(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)
          bundle.alufn = ALUFN_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)
          bundle.alufn = ALUFN_SRA;
        else
          ill = 1'b1;
      end
      OPC_OP_IMM: begin
        bundle.b     = imm_i;
        bundle.shamt = instr[24:20];
        bundle.alufn = f3_to_alufn(f3);
        if (f3 == 3'b001 && f7 != F7_BASE)
          ill = 1'b1;
        else if (f3 == 3'b101) begin
          if (f7 == F7_ALT)
            bundle.alufn = ALUFN_SRA;
          else if (f7 != F7_BASE)
            ill = 1'b1;
        end
      end
      OPC_LUI: begin
        bundle.alufn = ALUFN_PASSB;
        bundle.b     = imm_u;
      end
      OPC_AUIPC: begin
        bundle.a = pc;
        bundle.b = imm_u;
      end
      OPC_LOAD: begin
        bundle.b = imm_i;
        ill      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        bundle.b = imm_s;
        ill      = f3[2] || (f3 == 3'b011);
      end
      OPC_JALR: begin
        bundle.b = imm_i;
        ill      = (f3 != 3'b000);
      end
      OPC_JAL: begin
        bundle.a = pc;
        bundle.b = XLEN'(4);
      end
      OPC_BRANCH: begin
        case (f3[2:1])
          2'b00:   bundle.alufn = ALUFN_SUB;
          2'b10:   bundle.alufn = ALUFN_SLT;
          2'b11:   bundle.alufn = ALUFN_SLTU;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      bundle.alufn = ALUFN_ADD;
      bundle.a     = rs1;
      bundle.b     = rs2;
      bundle.shamt = '0;
    end
    bundle.illegal = ill;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a MAIN/SKID two-entry buffer with registered in_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alufn,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_shamt,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  issue_t dec;
  issue_t main_q;
  issue_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   issue;

  alu_op_decode #(.XLEN(XLEN)) u_decode (
    .instr  (in_instr),
    .pc     (in_pc),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .bundle (dec)
  );

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign issue    = main_valid & out_ready;

  // MAIN/SKID update; SKID can only fill while MAIN is held, so SKID is always older than a new beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || issue) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_alufn   = main_q.alufn;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_shamt   = main_q.shamt;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule
